// File: rtl/pipe_mux_pkg.sv
// Shared types and default sizing for the pipelined N:1 channel multiplexer.
package pipe_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 32;
  localparam int N_DEF     = 4;

endpackage

// File: rtl/pipe_mux_slot.sv
// One storage entry of the multiplexer: a {source, data} register with load enable.
module pipe_mux_slot #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_mux_n.sv
// Pipelined N:1 valid/ready multiplexer with a registered output and source tag.
// Define PIPE_MUX_SKID_EN for a 2-entry skid buffer with a fully registered IN_READY.
module pipe_mux_n
  import pipe_mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N     = N_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [N*WIDTH-1:0]     i_in_data,
  input  logic [N-1:0]           i_in_valid,
  output logic [N-1:0]           o_in_ready,
  input  logic [$clog2(N)-1:0]   i_sel,
  output logic [WIDTH-1:0]       o_out_data,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [$clog2(N)-1:0]   o_out_src,
  output logic                   o_sel_err
);

  localparam int SEL_W  = $clog2(N);
  localparam int SLOT_W = WIDTH + SEL_W;

  state_t            r_state;
  logic              r_sel_err;
  logic              w_sel_ok;
  logic              w_sel_valid;
  logic [WIDTH-1:0]  w_sel_data;
  logic              w_slot_ready;
  logic              w_accept;
  logic              w_out_xfer;
  logic              w_out_load;
  logic [SLOT_W-1:0] w_out_d;
  logic [SLOT_W-1:0] w_out_q;

  // Out-of-range selects match no channel, so nothing is offered or accepted.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (i_sel == SEL_W'(i)) begin
        w_sel_valid = i_in_valid[i];
        w_sel_data  = i_in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    o_in_ready = '0;
    for (int i = 0; i < N; i++) begin
      o_in_ready[i] = !i_reset && w_slot_ready && (i_sel == SEL_W'(i));
    end
  end

  assign w_sel_ok    = ({1'b0, i_sel} < (SEL_W+1)'(N));
  assign w_accept    = !i_reset && w_slot_ready && w_sel_valid;
  assign o_out_valid = (r_state != EMPTY);
  assign w_out_xfer  = o_out_valid && i_out_ready;

`ifdef PIPE_MUX_SKID_EN

  logic              r_in_rdy;
  logic              w_skid_load;
  logic [SLOT_W-1:0] w_skid_q;
  state_t            w_next;

  assign w_slot_ready = r_in_rdy;

  // In TWO no accept is possible, so the output entry can only refill from the skid entry.
  always_comb begin
    w_next      = r_state;
    w_out_load  = 1'b0;
    w_skid_load = 1'b0;
    w_out_d     = {i_sel, w_sel_data};
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_next     = ONE;
          w_out_load = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_out_xfer) begin
          w_out_load = 1'b1;
        end else if (w_accept) begin
          w_skid_load = 1'b1;
          w_next      = TWO;
        end else if (w_out_xfer) begin
          w_next = EMPTY;
        end
      end
      TWO: begin
        if (w_out_xfer) begin
          w_next     = ONE;
          w_out_load = 1'b1;
          w_out_d    = w_skid_q;
        end
      end
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= EMPTY;
      r_in_rdy <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_in_rdy <= (w_next != TWO);
    end
  end

  pipe_mux_slot #(.W(SLOT_W)) u_skid_slot (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_skid_load),
    .i_d     ({i_sel, w_sel_data}),
    .o_q     (w_skid_q)
  );

`else

  assign w_slot_ready = !o_out_valid || i_out_ready;
  assign w_out_load   = w_accept;
  assign w_out_d      = {i_sel, w_sel_data};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= EMPTY;
    end else if (w_accept) begin
      r_state <= ONE;
    end else if (w_out_xfer) begin
      r_state <= EMPTY;
    end
  end

`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= !w_sel_ok && (|i_in_valid);
    end
  end

  pipe_mux_slot #(.W(SLOT_W)) u_out_slot (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_out_load),
    .i_d     (w_out_d),
    .o_q     (w_out_q)
  );

  assign o_out_data = w_out_q[WIDTH-1:0];
  assign o_out_src  = w_out_q[SLOT_W-1 -: SEL_W];
  assign o_sel_err  = r_sel_err;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed bench for pipe_mux_n: a 4-channel instance driven against a queue model,
// plus a 3-channel instance for the out-of-range select case.
module tb_pipe_mux_n;

`ifdef PIPE_MUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam int W4 = 32;
  localparam int N4 = 4;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic reset;

  logic [N4*W4-1:0] d4InData;
  logic [N4-1:0]    d4InValid, d4InReady;
  logic [1:0]       d4Sel, d4OutSrc;
  logic [W4-1:0]    d4OutData;
  logic             d4OutValid, d4OutReady, d4SelErr;

  logic [N3*W3-1:0] d3InData;
  logic [N3-1:0]    d3InValid, d3InReady;
  logic [1:0]       d3Sel, d3OutSrc;
  logic [W3-1:0]    d3OutData;
  logic             d3OutValid, d3OutReady, d3SelErr;

  int checks   = 0;
  int failures = 0;
  int outCount = 0;
  logic [33:0] mq[$];
  logic [31:0] rx[$];

  always #5 clk = ~clk;

  pipe_mux_n #(.WIDTH(W4), .N(N4)) dut4 (
    .i_clk(clk), .i_reset(reset), .i_in_data(d4InData), .i_in_valid(d4InValid),
    .o_in_ready(d4InReady), .i_sel(d4Sel), .o_out_data(d4OutData), .o_out_valid(d4OutValid),
    .i_out_ready(d4OutReady), .o_out_src(d4OutSrc), .o_sel_err(d4SelErr)
  );

  pipe_mux_n #(.WIDTH(W3), .N(N3)) dut3 (
    .i_clk(clk), .i_reset(reset), .i_in_data(d3InData), .i_in_valid(d3InValid),
    .o_in_ready(d3InReady), .i_sel(d3Sel), .o_out_data(d3OutData), .o_out_valid(d3OutValid),
    .i_out_ready(d3OutReady), .o_out_src(d3OutSrc), .o_sel_err(d3SelErr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One clock of traffic on the 4-channel instance, checked against the queue model.
  task automatic applyStimulus(input logic [1:0] sel, input logic [N4-1:0] valid,
                               input logic [31:0] data, input logic outReady,
                               output logic accepted);
    logic expReady;
    logic [N4-1:0] expReadyVec;
    d4Sel      = sel;
    d4InValid  = valid;
    d4OutReady = outReady;
    for (int i = 0; i < N4; i++) begin
      d4InData[i*W4 +: W4] = (i == int'(sel)) ? data : (32'hBAD0_0000 | i);
    end
    #1;
    expReady    = SKID ? (mq.size() < 2) : (mq.size() == 0 || outReady);
    expReadyVec = expReady ? (4'b0001 << sel) : 4'b0000;
    checkOutput("in_ready", d4InReady, expReadyVec);
    if (d4OutValid && outReady) begin
      outCount++;
      rx.push_back(d4OutData);
    end
    @(posedge clk); #1;
    if (mq.size() > 0 && outReady) void'(mq.pop_front());
    accepted = valid[sel] && expReady;
    if (accepted) mq.push_back({sel, data});
    checkOutput("out_valid", d4OutValid, mq.size() > 0);
    if (mq.size() > 0) begin
      checkOutput("out_data", d4OutData, mq[0][31:0]);
      checkOutput("out_src", d4OutSrc, mq[0][33:32]);
    end
    checkOutput("sel_err4", d4SelErr, 1'b0);
  endtask

  task automatic resetCycle();
    reset     = 1'b1;
    d4InValid = 4'b1111;
    d4Sel     = 2'd1;
    #1;
    checkOutput("rst_in_ready", d4InReady, 4'b0000);
    @(posedge clk); #1;
    mq.delete();
    checkOutput("rst_out_valid", d4OutValid, 1'b0);
    checkOutput("rst_out_data", d4OutData, 32'h0);
    checkOutput("rst_out_src", d4OutSrc, 2'd0);
    checkOutput("rst_sel_err", d4SelErr, 1'b0);
    d4InValid = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic acc;
    int   w;
    reset = 1'b1;
    d4InData = '0; d4InValid = '0; d4Sel = '0; d4OutReady = 1'b0;
    d3InData = '0; d3InValid = '0; d3Sel = '0; d3OutReady = 1'b0;
    @(posedge clk); #1;
    resetCycle();
    checkOutput("rst_sel_err3", d3SelErr, 1'b0);
    checkOutput("rst_out_valid3", d3OutValid, 1'b0);
    reset = 1'b0;

    // Basic path on channel 2.
    applyStimulus(2'd2, 4'b0100, 32'hDEADBEEF, 1'b1, acc);
    checkOutput("basic_data", d4OutData, 32'hDEADBEEF);
    checkOutput("basic_src", d4OutSrc, 2'd2);
    applyStimulus(2'd2, 4'b0000, 32'h0, 1'b1, acc);

    // Backpressure: offer 1,2,3 on channel 0 while downstream stalls, then drain.
    rx.delete();
    w = 1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'd0, 4'b0001, w, 1'b0, acc);
      if (acc) w++;
    end
    checkOutput("bp_hold_data", d4OutData, 32'h1);
    checkOutput("bp_fill", mq.size(), SKID ? 2 : 1);
    for (int k = 0; k < 12 && (w <= 3 || mq.size() > 0); k++) begin
      applyStimulus(2'd0, (w <= 3) ? 4'b0001 : 4'b0000, w, 1'b1, acc);
      if (acc) w++;
    end
    checkOutput("bp_rx_count", rx.size(), 3);
    for (int k = 0; k < 3 && k < rx.size(); k++) begin
      checkOutput("bp_rx_order", rx[k], k + 1);
    end

    // Sustained throughput on channel 1.
    outCount = 0;
    w = 100;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(2'd1, 4'b0010, w, 1'b1, acc);
      if (acc) w++;
    end
    checkOutput("tput_words", outCount, 99);
    applyStimulus(2'd1, 4'b0000, 32'h0, 1'b1, acc);

    // Select switch between two accepts.
    applyStimulus(2'd0, 4'b0001, 32'h10, 1'b1, acc);
    checkOutput("sw_data0", d4OutData, 32'h10);
    checkOutput("sw_src0", d4OutSrc, 2'd0);
    applyStimulus(2'd3, 4'b1000, 32'h30, 1'b1, acc);
    checkOutput("sw_data3", d4OutData, 32'h30);
    checkOutput("sw_src3", d4OutSrc, 2'd3);
    applyStimulus(2'd3, 4'b0000, 32'h0, 1'b1, acc);

    // Reset while words are held.
    applyStimulus(2'd0, 4'b0001, 32'hAA, 1'b0, acc);
    applyStimulus(2'd0, 4'b0001, 32'hBB, 1'b0, acc);
    resetCycle();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'd0, 4'b0000, 32'h0, 1'b1, acc);
      checkOutput("post_rst_data", d4OutData, 32'h0);
    end

    // Out-of-range select on the 3-channel instance.
    d3Sel = 2'd1; d3InValid = 3'b010; d3InData = {8'h33, 8'h5A, 8'h11}; d3OutReady = 1'b0;
    #1;
    checkOutput("n3_ready_ch1", d3InReady, 3'b010);
    @(posedge clk); #1;
    checkOutput("n3_load_valid", d3OutValid, 1'b1);
    checkOutput("n3_load_data", d3OutData, 8'h5A);
    checkOutput("n3_load_src", d3OutSrc, 2'd1);
    d3Sel = 2'd3; d3InValid = 3'b111;
    #1;
    checkOutput("n3_bad_ready", d3InReady, 3'b000);
    @(posedge clk); #1;
    checkOutput("n3_sel_err_hi", d3SelErr, 1'b1);
    checkOutput("n3_hold_valid", d3OutValid, 1'b1);
    checkOutput("n3_hold_data", d3OutData, 8'h5A);
    d3InValid = 3'b000;
    @(posedge clk); #1;
    checkOutput("n3_sel_err_lo", d3SelErr, 1'b0);
    checkOutput("n3_still_valid", d3OutValid, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits.
REQ-002 Parameter N, default 4, number of input channels; SHALL be 2..16.
REQ-003 Derived localparam SEL_W = $clog2(N), width of the select and source fields.
REQ-004 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 IN_DATA  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 IN_VALID  input  N  per-channel valid.
REQ-008 IN_READY  output  N  per-channel ready.
REQ-009 SEL  input  SEL_W  binary channel select, sampled every cycle.
REQ-010 OUT_DATA  output  WIDTH  selected data, registered.
REQ-011 OUT_VALID  output  1  OUT_DATA holds a word.
REQ-012 OUT_READY  input  1  downstream accepts the word.
REQ-013 OUT_SRC  output  SEL_W  channel index the current OUT_DATA came from.
REQ-014 SEL_ERR  output  1  one-cycle registered pulse when SEL >= N and IN_VALID is nonzero.

Function
REQ-015 Transfer in: channel i is accepted when SEL==i, IN_VALID[i]==1 and IN_READY[i]==1 in the same cycle.
REQ-016 IN_READY[i] SHALL be 0 for every i != SEL; no unselected channel is ever accepted.
REQ-017 SEL >= N: no channel accepted, IN_READY all 0, state unchanged; SEL_ERR = 1 in the next cycle if any IN_VALID bit was 1.
REQ-018 Transfer out: occurs when OUT_VALID and OUT_READY are both 1.
REQ-019 Latency: an accepted word appears on OUT_DATA/OUT_VALID in the cycle after acceptance, given an empty block.
REQ-020 Words leave in acceptance order; none is dropped or duplicated.
REQ-021 OUT_DATA and OUT_SRC SHALL hold stable while OUT_VALID==1 and OUT_READY==0.
REQ-022 SEL change mid-stream SHALL NOT alter words already held; it affects only the next acceptance.
REQ-023 Simultaneous transfer in and out SHALL be supported without a bubble: 1 word/cycle sustained throughput.

Reset
REQ-024 RESET==1 at a clock edge: OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, SEL_ERR=0, state EMPTY, and all held words discarded.
REQ-025 While RESET==1, IN_READY SHALL be all 0; reset asserted mid-transfer discards the in-flight word with no partial output.

Configuration
REQ-026 Macro PIPE_MUX_SKID_EN defined: 2-entry skid buffer with states EMPTY, ONE, TWO.
- EMPTY: accept -> ONE.
- ONE: accept and no out-transfer -> TWO; accept and out-transfer -> ONE; out-transfer only -> EMPTY.
- TWO: out-transfer -> ONE (skid entry promoted to output).
- IN_READY[SEL] = (state != TWO), driven directly from a register with no combinational path from OUT_READY.
REQ-027 Macro PIPE_MUX_SKID_EN undefined: single output register.
- IN_READY[SEL] = !OUT_VALID || OUT_READY, a combinational path.
- States EMPTY and ONE only.
- All other REQs SHALL hold.

Structure
REQ-028 Shared package pipe_mux_pkg SHALL hold the state enum (EMPTY, ONE, TWO) and the default constants WIDTH_DEF=32 and N_DEF=4.
REQ-029 Sub-module pipe_mux_slot (a WIDTH+SEL_W data/source register with load enable) SHALL be instantiated for the output entry and for the skid entry.

Verification
REQ-030 Basic path: N=4, SEL=2, IN_VALID=4'b0100, ch2 data=0xDEADBEEF, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=0xDEADBEEF, OUT_SRC=2, IN_READY=4'b0100.
REQ-031 Backpressure (skid build): stream 0x1,0x2,0x3 on ch0 with OUT_READY=0 -> skid build: state reaches TWO, IN_READY[0] becomes 0 after 2 accepts, and 0x1 holds on output. Drain: OUT_READY=1 -> output order 0x1,0x2,0x3 with no loss.
REQ-032 Throughput: continuous valid on ch1 with OUT_READY=1 for 100 cycles -> 99 words output, one per cycle, with no gaps after the first.
REQ-033 Invalid select: N=3, SEL=3, IN_VALID=3'b111 -> IN_READY=0, SEL_ERR=1 the next cycle for exactly one cycle, and OUT_VALID unchanged.
REQ-034 Reset mid-operation: RESET=1 while in TWO with data 0xAA,0xBB held -> OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, and no 0xAA/0xBB appears after reset is released.
REQ-035 Select switch: SEL switches 0->3 between accepts of 0x10 (ch0) and 0x30 (ch3) -> output 0x10 with OUT_SRC=0, then 0x30 with OUT_SRC=3.
